data_step_sequencer: RTL and testbench

//  Sequences the 3-digit dekatron data counter (0..255, 8-4-2-1 coded) from a command interface.

---
 rtl/dpc_data_pkg.sv | 34 +++
 rtl/step_pulse_timer.sv | 34 +++
 rtl/data_step_sequencer.sv | 150 +++++++++++++++
 tb/tb_data_step_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_data_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : dpc_data_pkg
//  Purpose  : Shared command/state types and constants for the data counter
//             step sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package dpc_data_pkg;

    typedef enum logic [1:0] {
        OP_INC   = 2'd0,
        OP_DEC   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } data_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } seq_state_t;

    localparam logic [9:0] BCD_ZERO = 10'h000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module   : step_pulse_timer
//  Purpose  : Loadable down-counter; o_expire is high while the count is zero,
//             i.e. on the last cycle of a loaded interval.
//  Revision : 1.0  initial release
// ============================================================================
module step_pulse_timer #(
    parameter int MAX_CYC = 4,
    parameter int TW      = $clog2(MAX_CYC + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_expire
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/data_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : data_step_sequencer
//  Purpose  : Converts INC/DEC-by-N, LOAD and CLEAR commands into timed
//             Step/Reverse/Set pulses for the dekatron data counter.
//  Revision : 1.0  initial release
// ============================================================================
module data_step_sequencer
    import dpc_data_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int HIGH_CYC  = 4,
    parameter int LOW_CYC   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdOp,
    input  logic [CNT_W-1:0] CmdCount,
    input  logic [9:0]       CmdData,
    output logic             Done,
    output logic             Busy,
    output logic             Zero,
    output logic             CntStep,
    output logic             CntReverse,
    output logic             CntSet,
    output logic [9:0]       CntIn,
    input  logic [9:0]       CntOut
);

    localparam int TMR_MAX = max3(SETUP_CYC, HIGH_CYC, LOW_CYC);
    localparam int TW      = $clog2(TMR_MAX + 1);

    // Timer reload values are interval length minus one (expire on last cycle)
    localparam logic [TW-1:0] C_SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] C_HIGH_LD  = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] C_LOW_LD   = TW'(LOW_CYC - 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [CNT_W-1:0] r_remain;
    logic             r_reverse;
    logic             r_set_op;
    logic [9:0]       r_cnt_in;
    logic             r_zero;

    data_op_t         w_op;
    logic             w_accept;
    logic             w_is_set;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_expire;

    assign w_op     = data_op_t'(CmdOp);
    assign w_accept = CmdValid && (r_state == IDLE);
    assign w_is_set = (w_op == OP_LOAD) || (w_op == OP_CLEAR);

    step_pulse_timer #(
        .MAX_CYC (TMR_MAX),
        .TW      (TW)
    ) u_timer (
        .clk        (Clk),
        .rst        (Rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = C_SETUP_LD;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_is_set && (CmdCount == '0)) begin
                        w_next = FIN;
                    end else begin
                        w_next     = SETUP;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = C_SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (w_expire) begin
                    w_next     = PULSE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_HIGH_LD;
                end
            end
            PULSE: begin
                if (w_expire) begin
                    w_next     = GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_LOW_LD;
                end
            end
            GAP: begin
                if (w_expire) begin
                    if (r_remain == '0) begin
                        w_next = FIN;
                    end else begin
                        w_next     = PULSE;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = C_HIGH_LD;
                    end
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_remain  <= '0;
            r_reverse <= 1'b0;
            r_set_op  <= 1'b0;
            r_cnt_in  <= BCD_ZERO;
            r_zero    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_zero  <= (CntOut == BCD_ZERO);
            if (w_accept) begin
                r_reverse <= (w_op == OP_DEC);
                r_set_op  <= w_is_set;
                r_cnt_in  <= (w_op == OP_LOAD) ? CmdData : BCD_ZERO;
                r_remain  <= w_is_set ? CNT_W'(1) : CmdCount;
            end else if ((r_state == PULSE) && w_expire) begin
                // Remaining-step count drops as each Step pulse finishes
                r_remain <= r_remain - 1'b1;
            end
        end
    end

    assign CmdReady   = (r_state == IDLE);
    assign Busy       = (r_state != IDLE);
    assign Done       = (r_state == FIN);
    assign CntStep    = (r_state == PULSE);
    assign CntSet     = (r_state == PULSE) && r_set_op;
    assign CntReverse = Busy && r_reverse;
    assign CntIn      = Busy ? r_cnt_in : BCD_ZERO;
    assign Zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_data_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_step_sequencer
//  Purpose  : Bench for data_step_sequencer with an attached dekatron counter
//             model and a per-cycle expected-waveform model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_step_sequencer;

    localparam int S = 2;
    localparam int H = 4;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       Rst;
    logic       CmdValid;
    logic       CmdReady;
    logic [1:0] CmdOp;
    logic [7:0] CmdCount;
    logic [9:0] CmdData;
    logic       Done, Busy, Zero, CntStep, CntReverse, CntSet;
    logic [9:0] CntIn;
    logic [9:0] CntOut;

    always #5 clk = ~clk;

    data_step_sequencer #(
        .SETUP_CYC (S),
        .HIGH_CYC  (H),
        .LOW_CYC   (L),
        .CNT_W     (8)
    ) dut (
        .Clk        (clk),
        .Rst        (Rst),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdOp      (CmdOp),
        .CmdCount   (CmdCount),
        .CmdData    (CmdData),
        .Done       (Done),
        .Busy       (Busy),
        .Zero       (Zero),
        .CntStep    (CntStep),
        .CntReverse (CntReverse),
        .CntSet     (CntSet),
        .CntIn      (CntIn),
        .CntOut     (CntOut)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Dekatron counter model: acts on each rising Step
    function automatic int from_bcd(input logic [9:0] b);
        return int'(b[9:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction
    function automatic logic [9:0] to_bcd(input int v);
        return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    logic [9:0] cnt_bcd = 10'h000;
    logic       cstep_q = 1'b0;
    assign CntOut = cnt_bcd;

    always @(posedge clk) begin
        cstep_q <= CntStep;
        if (CntStep === 1'b1 && cstep_q === 1'b0) begin
            if (CntSet)          cnt_bcd <= CntIn;
            else if (CntReverse) cnt_bcd <= to_bcd((from_bcd(cnt_bcd) + 255) % 256);
            else                 cnt_bcd <= to_bcd((from_bcd(cnt_bcd) + 1) % 256);
        end
    end

    // Expected-waveform model: one entry per busy cycle of a command
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       step;
        logic       rev;
        logic       set;
        logic [9:0] cin;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic idle_k;
    logic exp_zero  = 1'b0;
    logic chk_en    = 1'b0;
    logic done_flag = 1'b0;
    logic prev_step = 1'b0;
    int   cyc = 0, accept_cyc = 0, done_cyc = 0, rises = 0;

    task automatic build_cmd(input logic [1:0] op, input logic [7:0] cnt, input logic [9:0] data);
        exp_t t;
        int   n;
        logic is_set;
        is_set = (op >= 2'd2);
        n      = is_set ? 1 : int'(cnt);
        t      = '0;
        t.busy = 1'b1;
        t.rev  = (op == 2'd1);
        t.cin  = (op == 2'd2) ? data : 10'h000;
        if (n > 0) begin
            repeat (S) q.push_back(t);
            for (int i = 0; i < n; i++) begin
                t.step = 1'b1; t.set = is_set;
                repeat (H) q.push_back(t);
                t.step = 1'b0; t.set = 1'b0;
                repeat (L) q.push_back(t);
            end
        end
        t.done = 1'b1;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            idle_k = (q.size() == 0);
            if (idle_k) e = '0;
            else        e = q.pop_front();
            chk("ready", CmdReady,   idle_k);
            chk("busy",  Busy,       e.busy);
            chk("done",  Done,       e.done);
            chk("step",  CntStep,    e.step);
            chk("rev",   CntReverse, e.rev);
            chk("set",   CntSet,     e.set);
            chk("cin",   CntIn,      e.cin);
            chk("zero",  Zero,       exp_zero);
            if (Done === 1'b1) begin
                done_flag = 1'b1;
                done_cyc  = cyc;
            end
            if (CntStep === 1'b1 && !prev_step) rises++;
            prev_step = (CntStep === 1'b1);
            if (Rst) begin
                q.delete();
            end else if (idle_k && CmdValid) begin
                accept_cyc = cyc;
                build_cmd(CmdOp, CmdCount, CmdData);
            end
            exp_zero = Rst ? 1'b0 : (CntOut == 10'h000);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] cnt, input logic [9:0] data);
        @(posedge clk); #1;
        done_flag = 1'b0;
        CmdValid  = 1'b1;
        CmdOp     = op;
        CmdCount  = cnt;
        CmdData   = data;
        @(posedge clk); #1;
        CmdValid  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!done_flag && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_flag) chk({name, "_timeout"}, 0, 1);
        else            chk({name, "_latency"}, done_cyc - accept_cyc, exp_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        Rst = 1'b1; CmdValid = 1'b0; CmdOp = 2'd0; CmdCount = 8'd0; CmdData = 10'h000;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("rst_ready", CmdReady, 1);
        chk("rst_busy",  Busy,     0);
        chk("rst_step",  CntStep,  0);
        chk("rst_zero",  Zero,     0);
        @(posedge clk); #1 Rst = 1'b0;
        repeat (3) @(posedge clk);

        // INC 3 from 000
        #1 rises = 0;
        issue(2'd0, 8'd3, 10'h000);
        wait_done("inc3", 1 + S + 3 * (H + L));
        chk("inc3_rises", rises,  3);
        chk("inc3_cnt",   CntOut, 10'h003);

        // LOAD 255, then DEC 2 with reverse set-up check
        issue(2'd2, 8'd0, 10'h255);
        wait_done("load255", 1 + S + (H + L));
        chk("load_cnt", CntOut, 10'h255);
        issue(2'd1, 8'd2, 10'h000);
        n = 0;
        while (CntStep !== 1'b1 && n < 50) begin
            if (CntReverse === 1'b1) n++;
            @(posedge clk); #1;
        end
        chk("dec_rev_setup", n, S);
        chk("dec_rev_at_step", CntReverse, 1);
        wait_done("dec2", 1 + S + 2 * (H + L));
        chk("dec2_cnt", CntOut, 10'h253);

        // Wrap 255 -> 000 and Zero on the cycle after Done
        issue(2'd2, 8'd0, 10'h255);
        wait_done("load255b", 1 + S + (H + L));
        chk("pre_wrap_zero", Zero, 0);
        issue(2'd0, 8'd1, 10'h000);
        wait_done("inc1", 1 + S + (H + L));
        chk("wrap_cnt",  CntOut, 10'h000);
        chk("wrap_zero", Zero,   1);

        // DEC 0: immediate Done, no Step
        #1 rises = 0;
        issue(2'd1, 8'd0, 10'h000);
        wait_done("dec0", 1);
        chk("dec0_rises", rises,  0);
        chk("dec0_cnt",   CntOut, 10'h000);

        // Command offered while busy is ignored
        @(posedge clk); #1;
        done_flag = 1'b0;
        CmdValid = 1'b1; CmdOp = 2'd0; CmdCount = 8'd2; CmdData = 10'h000;
        @(posedge clk); #1;
        CmdOp = 2'd2; CmdData = 10'h199;
        repeat (5) begin
            chk("busy_ready", CmdReady, 0);
            @(posedge clk); #1;
        end
        CmdValid = 1'b0;
        wait_done("inc2", 1 + S + 2 * (H + L));
        chk("busy_cnt", CntOut, 10'h002);
        repeat (3) @(posedge clk);
        chk("busy_no_exec", CntOut, 10'h002);

        // Reset in the middle of the first Step pulse of INC 5
        #1 rises = 0;
        issue(2'd0, 8'd5, 10'h000);
        n = 0;
        while (CntStep !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        Rst = 1'b1;
        @(posedge clk); #1;
        Rst = 1'b0;
        chk("mid_rst_step",  CntStep,  0);
        chk("mid_rst_busy",  Busy,     0);
        chk("mid_rst_ready", CmdReady, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_rises", rises,  1);
        chk("mid_rst_cnt",   CntOut, 10'h003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
